// File: rtl/mcpu_control_fsm_pkg.sv
// -----------------------------------------------------------------------------
// mcpu_control_fsm_pkg
//
// Shared encodings for the MCPU multi-cycle control unit: instruction opcodes
// and R-type function codes, ALU operation codes, datapath mux-select codes,
// the control-FSM state enumeration and a bundled control-word struct.
// The datapath and the control unit both import this package so that the
// encodings live in exactly one place.
// -----------------------------------------------------------------------------
package mcpu_control_fsm_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FUNCT_JR  = 6'h08;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_XOR  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;
    localparam logic [2:0] ALU_AND  = 3'd4;
    localparam logic [2:0] ALU_NAND = 3'd5;
    localparam logic [2:0] ALU_NOR  = 3'd6;
    localparam logic [2:0] ALU_OR   = 3'd7;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC   = 2'd0;
    localparam logic [1:0] SRCA_A    = 2'd1;
    localparam logic [1:0] SRCA_BEN  = 2'd2;
    localparam logic [1:0] SRCA_ZERO = 2'd3;

    // ALU operand B select
    localparam logic [1:0] SRCB_IMM_SHL2 = 2'd0;
    localparam logic [1:0] SRCB_IMM      = 2'd1;
    localparam logic [1:0] SRCB_B        = 2'd2;
    localparam logic [1:0] SRCB_FOUR     = 2'd3;

    // Next-PC select
    localparam logic [1:0] PCSRC_BRANCH = 2'd0;
    localparam logic [1:0] PCSRC_JUMP   = 2'd1;
    localparam logic [1:0] PCSRC_PC4    = 2'd2;
    localparam logic [1:0] PCSRC_ALU    = 2'd3;

    // Control FSM states
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_WB_ALU   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WB   = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_BR_TGT   = 4'd9,
        ST_BR_CMP   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_JAL      = 4'd12,
        ST_JR_EXEC  = 4'd13,
        ST_JR_PC    = 4'd14
    } state_t;

    // Every state-driven control output, bundled so a single '0 clears them all
    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       a_we;
        logic       b_we;
        logic       ben;
        logic       cheese;
        logic       mem_we;
        logic       reg_we;
        logic       mem_in;
        logic       dst;
        logic       reg_in;
        logic       jal;
        logic       beqbne;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

endpackage

// File: rtl/mcpu_ctrl_decode.sv
// -----------------------------------------------------------------------------
// mcpu_ctrl_decode
//
// Combinational instruction classifier for the control FSM. From the opcode
// and function fields it produces the state to enter after DECODE and the ALU
// operation used by the EXEC_R / EXEC_I states.
//
// Ports
//   i_opcode      in  6  instr[31:26]
//   i_funct       in  6  instr[5:0]
//   o_decode_next out 4  state_t to follow DECODE (FETCH for unsupported ops)
//   o_exec_alu_op out 3  ALU op for the execute state of R/I arithmetic
// -----------------------------------------------------------------------------
module mcpu_ctrl_decode
    import mcpu_control_fsm_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [3:0] o_decode_next,
    output logic [2:0] o_exec_alu_op
);

    // Dispatch after DECODE. Anything not in the supported subset falls back
    // to FETCH so it behaves as a two-cycle NOP with no writes.
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        o_decode_next = ST_FETCH;
        unique case (i_opcode)
            OP_RTYPE: begin
                unique case (i_funct)
                    FUNCT_JR:                        o_decode_next = ST_JR_EXEC;
                    FUNCT_ADD, FUNCT_SUB, FUNCT_SLT: o_decode_next = ST_EXEC_R;
                    default:                         o_decode_next = ST_FETCH;
                endcase
            end
            OP_LW, OP_SW:     o_decode_next = ST_MEM_ADDR;
            OP_ADDI, OP_XORI: o_decode_next = ST_EXEC_I;
            OP_BEQ, OP_BNE:   o_decode_next = ST_BR_TGT;
            OP_J:             o_decode_next = ST_JUMP;
            OP_JAL:           o_decode_next = ST_JAL;
            default:          o_decode_next = ST_FETCH;
        endcase
    end

    // ALU op for the execute states; only SUB, SLT and XORI differ from ADD.
    always_comb begin
        o_exec_alu_op = ALU_ADD;
        if (i_opcode == OP_RTYPE) begin
            if (i_funct == FUNCT_SUB) begin
                o_exec_alu_op = ALU_SUB;
            end else if (i_funct == FUNCT_SLT) begin
                o_exec_alu_op = ALU_SLT;
            end
        end else if (i_opcode == OP_XORI) begin
            o_exec_alu_op = ALU_XOR;
        end
    end

endmodule

// File: rtl/mcpu_control_fsm.sv
// -----------------------------------------------------------------------------
// mcpu_control_fsm
//
// Multi-cycle MIPS-subset control unit for the MCPU datapath. Slices the
// instruction register into its fields and runs a Moore FSM that drives every
// datapath enable and mux select. Holds no datapath storage of its own.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   instruction       in  32   IR contents
//   rs/rt/rd/shamt    out 5    instruction fields (combinational)
//   funct             out 6    instr[5:0]
//   imm               out 16   instr[15:0]
//   address           out 26   instr[25:0]
//   PC_WE..cheese     out 1    PC / IR / A / B / branch-PC+4 / PC+4 enables
//   Mem_WE, Reg_WE    out 1    memory and regfile write enables
//   MemIn             out 1    memory address: 0=PC, 1=ALU reg
//   Dst               out 1    write register: 0=rd, 1=rt
//   RegIn             out 1    write data: 0=MDR, 1=ALU reg
//   jal               out 1    forces write register 31
//   Immer             out 1    reserved, tied 0
//   BEQBNE            out 1    0=branch on zero, 1=branch on not-zero
//   ALUSrcA/ALUSrcB   out 2    ALU operand selects
//   ALUOp             out 3    ALU operation
//   PCSrc             out 2    next-PC select
// -----------------------------------------------------------------------------
module mcpu_control_fsm
    import mcpu_control_fsm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [25:0] address,
    output logic        PC_WE,
    output logic        IR_WE,
    output logic        A_WE,
    output logic        B_WE,
    output logic        BEN,
    output logic        cheese,
    output logic        Mem_WE,
    output logic        Reg_WE,
    output logic        MemIn,
    output logic        Dst,
    output logic        RegIn,
    output logic        jal,
    output logic        Immer,
    output logic        BEQBNE,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUOp,
    output logic [1:0]  PCSrc
);

    state_t     r_state;
    state_t     w_next_state;
    ctrl_t      w_ctrl;
    ctrl_t      w_ctrl_out;
    logic [5:0] w_opcode;
    logic [3:0] w_decode_next;
    logic [2:0] w_exec_alu_op;

    // ---------------------------------------------------------------------
    // Instruction field slicing
    // ---------------------------------------------------------------------
    assign w_opcode = instruction[31:26];
    assign rs       = instruction[25:21];
    assign rt       = instruction[20:16];
    assign rd       = instruction[15:11];
    assign shamt    = instruction[10:6];
    assign funct    = instruction[5:0];
    assign imm      = instruction[15:0];
    assign address  = instruction[25:0];

    mcpu_ctrl_decode u_decode (
        .i_opcode      (w_opcode),
        .i_funct       (instruction[5:0]),
        .o_decode_next (w_decode_next),
        .o_exec_alu_op (w_exec_alu_op)
    );

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // flop samples the pre-edge values regardless of process ordering.
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------------
    // Next state and Moore outputs
    // ---------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_ctrl       = '0;

        unique case (r_state)
            ST_FETCH: begin
                // Load IR and compute PC+4 into the ALU reg / PC+4 save reg.
                w_ctrl.ir_we     = 1'b1;
                w_ctrl.cheese    = 1'b1;
                w_ctrl.alu_src_a = SRCA_PC;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.alu_op    = ALU_ADD;
                w_next_state     = ST_DECODE;
            end
            ST_DECODE: begin
                // Commit the saved PC+4 and read the register operands. The
                // ALU recomputes PC+4 from the old PC so the ALU reg holds it
                // again on entry to the next state.
                w_ctrl.a_we      = 1'b1;
                w_ctrl.b_we      = 1'b1;
                w_ctrl.pc_we     = 1'b1;
                w_ctrl.pc_src    = PCSRC_PC4;
                w_ctrl.alu_src_a = SRCA_PC;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.alu_op    = ALU_ADD;
                w_next_state     = state_t'(w_decode_next);
            end
            ST_EXEC_R: begin
                w_ctrl.alu_src_a = SRCA_A;
                w_ctrl.alu_src_b = SRCB_B;
                w_ctrl.alu_op    = w_exec_alu_op;
                w_next_state     = ST_WB_ALU;
            end
            ST_EXEC_I: begin
                w_ctrl.alu_src_a = SRCA_A;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = w_exec_alu_op;
                w_next_state     = ST_WB_ALU;
            end
            ST_WB_ALU: begin
                // R-type writes rd, I-type writes rt.
                w_ctrl.reg_we = 1'b1;
                w_ctrl.reg_in = 1'b1;
                w_ctrl.dst    = (w_opcode != OP_RTYPE);
                w_next_state  = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                w_ctrl.alu_src_a = SRCA_A;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALU_ADD;
                w_next_state     = (w_opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                w_ctrl.mem_in = 1'b1;
                w_next_state  = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                w_ctrl.reg_we = 1'b1;
                w_ctrl.reg_in = 1'b0;
                w_ctrl.dst    = 1'b1;
                w_next_state  = ST_FETCH;
            end
            ST_MEM_WR: begin
                w_ctrl.mem_in = 1'b1;
                w_ctrl.mem_we = 1'b1;
                w_next_state  = ST_FETCH;
            end
            ST_BR_TGT: begin
                // BEN latches PC+4 (fall-through) while the ALU forms the
                // branch target from the already-advanced PC.
                w_ctrl.ben       = 1'b1;
                w_ctrl.alu_src_a = SRCA_PC;
                w_ctrl.alu_src_b = SRCB_IMM_SHL2;
                w_ctrl.alu_op    = ALU_ADD;
                w_next_state     = ST_BR_CMP;
            end
            ST_BR_CMP: begin
                // Datapath picks ALU reg (target) or BEN reg (fall-through)
                // from the zero flag, inverted for BNE via opcode bit 0.
                w_ctrl.alu_src_a = SRCA_A;
                w_ctrl.alu_src_b = SRCB_B;
                w_ctrl.alu_op    = ALU_SUB;
                w_ctrl.beqbne    = w_opcode[0];
                w_ctrl.pc_we     = 1'b1;
                w_ctrl.pc_src    = PCSRC_BRANCH;
                w_next_state     = ST_FETCH;
            end
            ST_JUMP: begin
                w_ctrl.pc_we  = 1'b1;
                w_ctrl.pc_src = PCSRC_JUMP;
                w_next_state  = ST_FETCH;
            end
            ST_JAL: begin
                // ALU reg still holds PC+4 from DECODE; write it to $31.
                w_ctrl.pc_we  = 1'b1;
                w_ctrl.pc_src = PCSRC_JUMP;
                w_ctrl.reg_we = 1'b1;
                w_ctrl.jal    = 1'b1;
                w_ctrl.reg_in = 1'b1;
                w_next_state  = ST_FETCH;
            end
            ST_JR_EXEC: begin
                // rs + $0 routes the jump target through the ALU reg.
                w_ctrl.alu_src_a = SRCA_A;
                w_ctrl.alu_src_b = SRCB_B;
                w_ctrl.alu_op    = ALU_ADD;
                w_next_state     = ST_JR_PC;
            end
            ST_JR_PC: begin
                w_ctrl.pc_we  = 1'b1;
                w_ctrl.pc_src = PCSRC_ALU;
                w_next_state  = ST_FETCH;
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    // While reset is high every enable and select is forced low, so an
    // instruction interrupted by reset commits nothing in that cycle.
    assign w_ctrl_out = reset ? '0 : w_ctrl;

    assign PC_WE   = w_ctrl_out.pc_we;
    assign IR_WE   = w_ctrl_out.ir_we;
    assign A_WE    = w_ctrl_out.a_we;
    assign B_WE    = w_ctrl_out.b_we;
    assign BEN     = w_ctrl_out.ben;
    assign cheese  = w_ctrl_out.cheese;
    assign Mem_WE  = w_ctrl_out.mem_we;
    assign Reg_WE  = w_ctrl_out.reg_we;
    assign MemIn   = w_ctrl_out.mem_in;
    assign Dst     = w_ctrl_out.dst;
    assign RegIn   = w_ctrl_out.reg_in;
    assign jal     = w_ctrl_out.jal;
    assign Immer   = 1'b0;
    assign BEQBNE  = w_ctrl_out.beqbne;
    assign ALUSrcA = w_ctrl_out.alu_src_a;
    assign ALUSrcB = w_ctrl_out.alu_src_b;
    assign ALUOp   = w_ctrl_out.alu_op;
    assign PCSrc   = w_ctrl_out.pc_src;

endmodule

// File: tb/tb_mcpu_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mcpu_control_fsm
//
// Scoreboard bench for the MCPU control unit. The driver issues instructions
// (directed, then random) and, for each cycle it drives, pushes the expected
// control word from an instruction-level reference model. A separate monitor
// pops one entry per cycle at the falling edge and compares control outputs
// and instruction fields.
// -----------------------------------------------------------------------------
module tb_mcpu_control_fsm;

    // Expected control outputs, in the bench's own packing order
    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       a_we;
        logic       b_we;
        logic       ben;
        logic       cheese;
        logic       mem_we;
        logic       reg_we;
        logic       mem_in;
        logic       dst;
        logic       reg_in;
        logic       jal;
        logic       immer;
        logic       beqbne;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
    } cw_t;

    typedef struct {
        logic [31:0] ins;
        cw_t         cw;
        int          step;
        string       tag;
    } exp_t;

    bit          clk;
    logic        reset;
    logic [31:0] instruction;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] address;
    logic        PC_WE, IR_WE, A_WE, B_WE, BEN, cheese, Mem_WE, Reg_WE;
    logic        MemIn, Dst, RegIn, jal, Immer, BEQBNE;
    logic [1:0]  ALUSrcA, ALUSrcB, PCSrc;
    logic [2:0]  ALUOp;

    int    n_tests = 0;
    int    n_fails = 0;
    bit    running = 0;
    exp_t  sb[$];
    cw_t   plan[$];
    string plan_tag;

    mcpu_control_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .imm         (imm),
        .address     (address),
        .PC_WE       (PC_WE),
        .IR_WE       (IR_WE),
        .A_WE        (A_WE),
        .B_WE        (B_WE),
        .BEN         (BEN),
        .cheese      (cheese),
        .Mem_WE      (Mem_WE),
        .Reg_WE      (Reg_WE),
        .MemIn       (MemIn),
        .Dst         (Dst),
        .RegIn       (RegIn),
        .jal         (jal),
        .Immer       (Immer),
        .BEQBNE      (BEQBNE),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSrc       (PCSrc)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Reference model: cycle-by-cycle control words for one instruction
    // ---------------------------------------------------------------------
    function automatic cw_t cw_fetch();
        cw_t c = '0;
        c.ir_we = 1; c.cheese = 1; c.src_a = 0; c.src_b = 3; c.alu_op = 0;
        return c;
    endfunction

    function automatic cw_t cw_decode();
        cw_t c = '0;
        c.a_we = 1; c.b_we = 1; c.pc_we = 1; c.pc_src = 2; c.src_a = 0; c.src_b = 3;
        return c;
    endfunction

    function automatic void build_plan(input logic [31:0] ins);
        int   op = int'(ins >> 26);
        int   fn = int'(ins & 32'h3F);
        cw_t  c;
        plan.delete();
        plan.push_back(cw_fetch());
        plan.push_back(cw_decode());
        plan_tag = "nop";
        if (op == 0 && (fn == 'h20 || fn == 'h22 || fn == 'h2A)) begin
            plan_tag = "rtype";
            c = '0; c.src_a = 1; c.src_b = 2;
            c.alu_op = (fn == 'h20) ? 3'd0 : (fn == 'h22) ? 3'd1 : 3'd3;
            plan.push_back(c);
            c = '0; c.reg_we = 1; c.reg_in = 1; c.dst = 0;
            plan.push_back(c);
        end else if (op == 0 && fn == 'h08) begin
            plan_tag = "jr";
            c = '0; c.src_a = 1; c.src_b = 2; c.alu_op = 0;
            plan.push_back(c);
            c = '0; c.pc_we = 1; c.pc_src = 3;
            plan.push_back(c);
        end else if (op == 'h08 || op == 'h0E) begin
            plan_tag = "itype";
            c = '0; c.src_a = 1; c.src_b = 1; c.alu_op = (op == 'h0E) ? 3'd2 : 3'd0;
            plan.push_back(c);
            c = '0; c.reg_we = 1; c.reg_in = 1; c.dst = 1;
            plan.push_back(c);
        end else if (op == 'h23 || op == 'h2B) begin
            plan_tag = (op == 'h23) ? "lw" : "sw";
            c = '0; c.src_a = 1; c.src_b = 1; c.alu_op = 0;
            plan.push_back(c);
            if (op == 'h23) begin
                c = '0; c.mem_in = 1;
                plan.push_back(c);
                c = '0; c.reg_we = 1; c.reg_in = 0; c.dst = 1;
                plan.push_back(c);
            end else begin
                c = '0; c.mem_in = 1; c.mem_we = 1;
                plan.push_back(c);
            end
        end else if (op == 'h04 || op == 'h05) begin
            plan_tag = "branch";
            c = '0; c.ben = 1; c.src_a = 0; c.src_b = 0; c.alu_op = 0;
            plan.push_back(c);
            c = '0; c.src_a = 1; c.src_b = 2; c.alu_op = 1; c.beqbne = (op == 'h05);
            c.pc_we = 1; c.pc_src = 0;
            plan.push_back(c);
        end else if (op == 'h02 || op == 'h03) begin
            plan_tag = (op == 'h03) ? "jal" : "j";
            c = '0; c.pc_we = 1; c.pc_src = 1;
            if (op == 'h03) begin
                c.reg_we = 1; c.jal = 1; c.reg_in = 1;
            end
            plan.push_back(c);
        end
    endfunction

    // ---------------------------------------------------------------------
    // Driver: one push per driven cycle; abort_after>0 injects reset
    // ---------------------------------------------------------------------
    task automatic push_cycle(input logic [31:0] ins, input cw_t cw, input int step,
                              input string tag);
        exp_t e;
        e.ins = ins; e.cw = cw; e.step = step; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic run_instr(input logic [31:0] ins, input int abort_after);
        int n;
        string tag;
        build_plan(ins);
        tag = plan_tag;
        n = (abort_after > 0 && abort_after < plan.size()) ? abort_after : plan.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            reset = 0;
            instruction = ins;
            push_cycle(ins, plan[i], i, tag);
        end
        if (n < plan.size()) begin
            @(posedge clk); #1;
            reset = 1;
            push_cycle(ins, '0, n, {tag, "_reset"});
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [5:0]  rf [3];
        logic [5:0]  io [2];
        rf[0] = 6'h20; rf[1] = 6'h22; rf[2] = 6'h2A;
        io[0] = 6'h08; io[1] = 6'h0E;
        r = $urandom();
        case ($urandom_range(0, 9))
            0:       begin r[31:26] = 6'h00; r[5:0] = rf[$urandom_range(0, 2)]; end
            1:       begin r[31:26] = 6'h00; r[5:0] = 6'h08; r[20:16] = 5'd0; end
            2:       r[31:26] = 6'h00;
            3:       r[31:26] = 6'h23;
            4:       r[31:26] = 6'h2B;
            5:       r[31:26] = io[$urandom_range(0, 1)];
            6:       r[31:26] = 6'h04 | 6'($urandom_range(0, 1));
            7:       r[31:26] = 6'h02 | 6'($urandom_range(0, 1));
            default: ;
        endcase
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // Monitor: one scoreboard entry per cycle, sampled at the falling edge
    // ---------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t        e;
        cw_t         got;
        logic [67:0] got_f, exp_f;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            got = {PC_WE, IR_WE, A_WE, B_WE, BEN, cheese, Mem_WE, Reg_WE, MemIn, Dst,
                   RegIn, jal, Immer, BEQBNE, ALUSrcA, ALUSrcB, ALUOp, PCSrc};
            n_tests++;
            if (got !== e.cw) begin
                n_fails++;
                $display("FAIL ctl %s step %0d instr %h: got %h expected %h",
                         e.tag, e.step, e.ins, got, e.cw);
            end
            exp_f = {5'((e.ins >> 21) & 32'h1F), 5'((e.ins >> 16) & 32'h1F),
                     5'((e.ins >> 11) & 32'h1F), 5'((e.ins >> 6) & 32'h1F),
                     6'(e.ins & 32'h3F), 16'(e.ins & 32'hFFFF), 26'(e.ins & 32'h3FF_FFFF)};
            got_f = {rs, rt, rd, shamt, funct, imm, address};
            n_tests++;
            if (got_f !== exp_f) begin
                n_fails++;
                $display("FAIL fields %s step %0d instr %h: got %h expected %h",
                         e.tag, e.step, e.ins, got_f, exp_f);
            end
        end else if (running) begin
            n_tests++;
            n_fails++;
            $display("FAIL underflow: no expected entry for cycle at %0t", $time);
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        reset = 1;
        instruction = 32'h0;

        // Two cycles of reset: everything must read zero
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            push_cycle(32'h0, '0, i, "reset");
            running = 1;
        end

        // Directed instructions
        run_instr(32'h0085_1020, 0);  // add $2,$4,$5
        run_instr(32'h8C88_0004, 0);  // lw $8,4($4)
        run_instr(32'hAC88_0004, 0);  // sw $8,4($4)
        run_instr(32'h1085_0003, 0);  // beq
        run_instr(32'h1485_0003, 0);  // bne
        run_instr(32'h0800_0010, 0);  // j
        run_instr(32'h0C00_0010, 0);  // jal
        run_instr(32'h03E0_0008, 0);  // jr $31
        run_instr(32'hFC00_0000, 0);  // unsupported opcode 0x3F
        run_instr(32'h0085_1022, 0);  // sub
        run_instr(32'h0085_102A, 0);  // slt
        run_instr(32'h2082_FFFF, 0);  // addi
        run_instr(32'h3882_00FF, 0);  // xori
        run_instr(32'h0085_1024, 0);  // unsupported funct (and) -> nop

        // Reset mid-instruction: no enable may assert in the reset cycle
        run_instr(32'h8C88_0004, 2);  // lw aborted after decode
        run_instr(32'h1485_0003, 3);  // bne aborted in compare
        run_instr(32'h0C00_0010, 2);  // jal aborted in its write cycle
        run_instr(32'h0085_1020, 0);

        // Randomized instruction stream
        for (int k = 0; k < 80; k++) begin
            run_instr(gen_instr(), ($urandom_range(0, 15) == 0) ? 2 + int'($urandom_range(0, 2)) : 0);
        end
        run_instr(32'h0085_1020, 0);

        @(negedge clk); #1;
        running = 0;
        n_tests++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL drain: got %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
